// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// valid/ready producers, granting one producer at a time for up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                          busy
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_GRANT = 1'b1;
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(MAX_BURST - 1);

    // First valid producer after 'last', wrapping NUM_REQ-1 -> 0.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    logic [0:0]         state_q, state_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic               gnt_valid_s;
    logic               xfer_s;
    logic [NUM_REQ-1:0] ready_s;

    assign gnt_valid_s = req_valid[grant_id_q];

    // Next-state, arbitration and handshake logic.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        beat_cnt_d = beat_cnt_q;
        xfer_s     = 1'b0;
        ready_s    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_id_d = rr_pick(req_valid, last_id_q);
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                xfer_s              = gnt_valid_s & ~fifo_full;
                ready_s[grant_id_q] = xfer_s;
                if (!gnt_valid_s) begin
                    state_d   = ST_IDLE;
                    last_id_d = grant_id_q;
                end else if (xfer_s) begin
                    if (beat_cnt_q == BC_LAST) begin
                        state_d    = ST_IDLE;
                        last_id_d  = grant_id_q;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BC_W'(1);
                    end
                end else begin
                    // full stall: hold grant and beat count
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset; producer 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            last_id_q  <= LAST_RST;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy       = (state_q == ST_GRANT);
    assign fifo_cs    = (state_q == ST_GRANT);
    assign fifo_wr_en = xfer_s;
    assign req_ready  = ready_s;
    assign grant_id   = grant_id_q;
    assign fifo_data  = req_data[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus hand-written
// sequences for full stall, reset mid-burst and held reset.
module tb_fifo_wr_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_full;
    logic         fifo_cs;
    logic         fifo_wr_en;
    logic [31:0]  fifo_data;
    logic [1:0]   grant_id;
    logic         busy;

    int tests;
    int fails;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_cs(fifo_cs),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .grant_id(grant_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  v;
        logic [23:0] base;
        logic        full;
        logic [3:0]  rdy;
        logic        wr;
        logic [1:0]  gid;
        logic        busy;
        logic [31:0] fd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [3:0] v, input logic [23:0] base,
                       input logic [3:0] rdy, input logic wr, input logic [1:0] gid,
                       input logic bsy, input logic [31:0] fd);
        vec_t t;
        t.name = name; t.v = v; t.base = base; t.full = 1'b0; t.rdy = rdy;
        t.wr = wr; t.gid = gid; t.busy = bsy; t.fd = fd;
        vecs.push_back(t);
    endtask

    // Producer i presents {i, base}.
    task automatic drive(input logic [3:0] v, input logic [23:0] base, input logic full);
        req_valid = v;
        fifo_full = full;
        for (int i = 0; i < 4; i++) begin
            req_data[i*32 +: 32] = {i[7:0], base};
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " wr"}, 32'(fifo_wr_en), 32'd0);
        chk({name, " cs"}, 32'(fifo_cs), 32'd0);
        chk({name, " rdy"}, 32'(req_ready), 32'd0);
        chk({name, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        tests = 0;
        fails = 0;
        drive(4'b0000, 24'h0, 1'b0);

        // fairness: producers 0 and 2 always valid
        add("fair idle0", 4'b0101, 24'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);
        add("fair p0b1",  4'b0101, 24'h11, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00000011);
        add("fair p0b2",  4'b0101, 24'h12, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00000012);
        add("fair p0b3",  4'b0101, 24'h13, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00000013);
        add("fair p0b4",  4'b0101, 24'h14, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00000014);
        add("fair bub1",  4'b0101, 24'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);
        add("fair p2b1",  4'b0101, 24'h21, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h02000021);
        add("fair p2b2",  4'b0101, 24'h22, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h02000022);
        add("fair p2b3",  4'b0101, 24'h23, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h02000023);
        add("fair p2b4",  4'b0101, 24'h24, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h02000024);
        add("fair bub2",  4'b0101, 24'h0,  4'b0000, 1'b0, 2'd2, 1'b0, 32'h0);
        add("fair p0c1",  4'b0101, 24'h31, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00000031);
        add("fair p0c2",  4'b0101, 24'h32, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00000032);
        add("fair p0c3",  4'b0101, 24'h33, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00000033);
        add("fair p0c4",  4'b0101, 24'h34, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h00000034);
        add("fair end",   4'b0000, 24'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);
        // single producer 1 with three words then withdraw
        add("one idle",   4'b0010, 24'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);
        add("one A1",     4'b0010, 24'hA1, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h010000A1);
        add("one A2",     4'b0010, 24'hA2, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h010000A2);
        add("one A3",     4'b0010, 24'hA3, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h010000A3);
        add("one drop",   4'b0000, 24'h0,  4'b0000, 1'b0, 2'd1, 1'b1, 32'h0);
        add("one idle2",  4'b0000, 24'h0,  4'b0000, 1'b0, 2'd1, 1'b0, 32'h0);
        // wrap-around: serve 3, then 0 wins; with only 3 valid, 3 again
        add("wrap idle",  4'b1000, 24'h0,  4'b0000, 1'b0, 2'd1, 1'b0, 32'h0);
        add("wrap p3",    4'b1000, 24'hC1, 4'b1000, 1'b1, 2'd3, 1'b1, 32'h030000C1);
        add("wrap drop3", 4'b0000, 24'h0,  4'b0000, 1'b0, 2'd3, 1'b1, 32'h0);
        add("wrap arb",   4'b1001, 24'h0,  4'b0000, 1'b0, 2'd3, 1'b0, 32'h0);
        add("wrap p0",    4'b1001, 24'hD1, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h000000D1);
        add("wrap drop0", 4'b1000, 24'h0,  4'b0000, 1'b0, 2'd0, 1'b1, 32'h0);
        add("wrap arb2",  4'b1000, 24'h0,  4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);
        add("wrap p3b",   4'b1000, 24'hE1, 4'b1000, 1'b1, 2'd3, 1'b1, 32'h030000E1);
        add("wrap drop3b",4'b0000, 24'h0,  4'b0000, 1'b0, 2'd3, 1'b1, 32'h0);
        add("wrap arb3",  4'b1000, 24'h0,  4'b0000, 1'b0, 2'd3, 1'b0, 32'h0);
        add("wrap p3c",   4'b1000, 24'hF1, 4'b1000, 1'b1, 2'd3, 1'b1, 32'h030000F1);
        add("wrap drop3c",4'b0000, 24'h0,  4'b0000, 1'b0, 2'd3, 1'b1, 32'h0);
        add("wrap idle3", 4'b0000, 24'h0,  4'b0000, 1'b0, 2'd3, 1'b0, 32'h0);

        // reset values before any clock edge
        #2;
        chk_idle("reset");
        chk("reset gid", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].base, vecs[k].full);
            #4;
            chk({vecs[k].name, " rdy"}, 32'(req_ready), 32'(vecs[k].rdy));
            chk({vecs[k].name, " wr"}, 32'(fifo_wr_en), 32'(vecs[k].wr));
            chk({vecs[k].name, " cs"}, 32'(fifo_cs), 32'(vecs[k].busy));
            chk({vecs[k].name, " busy"}, 32'(busy), 32'(vecs[k].busy));
            chk({vecs[k].name, " gid"}, 32'(grant_id), 32'(vecs[k].gid));
            if (vecs[k].wr) chk({vecs[k].name, " data"}, fifo_data, vecs[k].fd);
            @(negedge clk);
        end

        // full stall after beat 2 of a producer-2 burst
        drive(4'b0100, 24'h51, 1'b0);
        #4; chk("stall idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        for (int b = 1; b <= 2; b++) begin
            drive(4'b0100, 24'h50 + 24'(b), 1'b0);
            #4;
            chk("stall pre wr", 32'(fifo_wr_en), 32'd1);
            chk("stall pre data", fifo_data, 32'h02000050 + 32'(b));
            @(negedge clk);
        end
        for (int s = 0; s < 5; s++) begin
            drive(4'b0100, 24'h53, 1'b1);
            #4;
            chk("stall wr", 32'(fifo_wr_en), 32'd0);
            chk("stall rdy", 32'(req_ready), 32'd0);
            chk("stall busy", 32'(busy), 32'd1);
            chk("stall gid", 32'(grant_id), 32'd2);
            chk("stall beat_cnt", 32'(dut.beat_cnt_q), 32'd2);
            @(negedge clk);
        end
        for (int b = 3; b <= 4; b++) begin
            drive(4'b0100, 24'h50 + 24'(b), 1'b0);
            #4;
            chk("stall post wr", 32'(fifo_wr_en), 32'd1);
            chk("stall post rdy", 32'(req_ready), 32'b0100);
            chk("stall post data", fifo_data, 32'h02000050 + 32'(b));
            @(negedge clk);
        end
        drive(4'b0100, 24'h55, 1'b0);
        #4; chk_idle("stall release");
        @(negedge clk);
        #4; chk("stall regrant gid", 32'(grant_id), 32'd2);
        chk("stall regrant busy", 32'(busy), 32'd1);
        @(negedge clk);
        drive(4'b0000, 24'h0, 1'b0);
        #4; chk("stall drop wr", 32'(fifo_wr_en), 32'd0);
        @(negedge clk);

        // reset pulsed during beat 2 of a producer-2 burst
        drive(4'b0100, 24'h61, 1'b0);
        @(negedge clk);
        #4; chk("rstmid b1 wr", 32'(fifo_wr_en), 32'd1);
        @(negedge clk);
        drive(4'b0100, 24'h62, 1'b0);
        #1; chk("rstmid b2 wr", 32'(fifo_wr_en), 32'd1);
        #1; rst_n = 1'b0;
        #1;
        chk_idle("rstmid");
        chk("rstmid gid", 32'(grant_id), 32'd0);
        chk("rstmid data", fifo_data, 32'h00000062);
        @(negedge clk);
        drive(4'b0101, 24'h71, 1'b0);
        rst_n = 1'b1;
        #4; chk_idle("rstmid idle");
        @(negedge clk);
        #4;
        chk("rstmid first gid", 32'(grant_id), 32'd0);
        chk("rstmid first rdy", 32'(req_ready), 32'b0001);
        chk("rstmid first data", fifo_data, 32'h00000071);
        @(negedge clk);

        // held reset ignores all requests
        rst_n = 1'b0;
        drive(4'b1111, 24'h81, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #4;
            chk_idle("hold");
            chk("hold gid", 32'(grant_id), 32'd0);
            chk("hold data", fifo_data, 32'h00000081);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's cs/wr_en/data_in from the granted producer, honouring the FIFO full flag. It sits directly in front of the sync FIFO and replaces per-producer direct wiring.

## Interface
- NUM_REQ, 4, number of producers (>= 2)
- DATA_WIDTH, 32, data word width; matches the FIFO
- MAX_BURST, 4, maximum beats per grant (>= 1)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-producer valid
- req_data  in  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-producer ready; one-hot or zero
- fifo_full  in  1  FIFO full flag
- fifo_cs  out  1  FIFO chip select
- fifo_wr_en  out  1  FIFO write enable
- fifo_data  out  DATA_WIDTH  FIFO write data
- grant_id  out  max(1,$clog2(NUM_REQ))  current or last granted producer
- busy  out  1  high in GRANT state

## Operation
- State machine with two states, IDLE and GRANT. Registers: state, grant_id, last_id, beat_cnt (max(1,$clog2(MAX_BURST)) bits).
- IDLE:
  - If any req_valid is set, select the first set bit scanning last_id+1, last_id+2, … modulo NUM_REQ (wraps NUM_REQ-1 -> 0).
  - Load grant_id with the selection, clear beat_cnt, go to GRANT.
  - No transfer happens in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = req_valid[g] & !fifo_full; all other ready bits are 0.
  - fifo_wr_en = req_valid[g] & !fifo_full.
  - fifo_cs = 1.
  - fifo_data = slice g of req_data. It is combinational from the producer; this path has no register.
  - A transfer is any cycle with fifo_wr_en = 1. A transfer increments beat_cnt.
- Release from GRANT to IDLE, with last_id <= g, happens when either:
  - a transfer occurs with beat_cnt == MAX_BURST-1, or
  - req_valid[g] == 0 (producer withdrew; no transfer that cycle).
- fifo_full high in GRANT: the grant is held, no beat is counted, and there is no timeout.
- Producer rule: req_data is held stable while valid & !ready. Dropping valid is permitted and releases the grant.
- Non-granted producers see ready = 0 and wait; there is no starvation. Every producer is served within NUM_REQ grants.
- Outputs in IDLE: fifo_cs = 0, fifo_wr_en = 0, req_ready = 0, busy = 0.

## Timing
- Reset (asynchronous) values:
  - state = IDLE, grant_id = 0, last_id = NUM_REQ-1 (producer 0 wins first), beat_cnt = 0.
  - All outputs low; fifo_data = slice 0.
- Reset asserted mid-burst aborts the burst immediately. The beat in flight is not written (wr_en drops combinationally with state).
- Grant latency: req_valid high before edge N -> GRANT and ready visible in the cycle after edge N -> first write at edge N+1.
- Throughput: 1 beat/cycle inside a burst. Exactly one IDLE bubble cycle between consecutive grants.
- A release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle. last_id is already updated at that point.
- A full -> not-full transition mid-burst resumes transfers in the same cycle that fifo_full is seen low.

## Test plan
- Single producer: producer 1 valid with 3 words (0xA1, 0xA2, 0xA3), then drops valid, MAX_BURST=4.
  - Response: grant_id=1, three consecutive writes of A1,A2,A3, one cycle with valid low in GRANT, then IDLE.
- Fairness: producers 0 and 2 continuously valid, MAX_BURST=4.
  - Response: 4 writes from 0, 1 bubble, 4 writes from 2, 1 bubble, 4 from 0.
  - FIFO receives beats in exactly this order.
- Wrap-around: producers 0 and 3 valid, last_id=3 after serving 3.
  - Response: next grant is 0.
  - With only 3 valid after 3 is served, the next grant is 3 again.
- Full stall: fifo_full forced high for 5 cycles after beat 2 of a burst.
  - Response: wr_en=0 and ready=0 for those 5 cycles, grant held, beat_cnt stays 2.
  - The burst then completes with beats 3 and 4, no data lost or duplicated.
- Reset mid-burst: rst_n pulsed low during beat 2.
  - Response: all outputs 0 immediately; after release, producer 0 wins first.
- Reset values: hold rst_n low.
  - Response: all outputs low, busy=0, grant_id=0, and req_ready stays 0 regardless of req_valid.
